// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through register-file bypass, load-use
// hazard detection (one bubble per hazard) and a saturating bubble counter.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_a1,
   input  logic [ADDR_W-1:0] id_a2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_stall,
   input  logic              flush,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [ADDR_W-1:0] ex_rd,
   output logic              ex_we,
   output logic              ex_is_load,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [15:0]       bubble_cnt
);

   logic              hazard;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;

   always_comb begin
      hazard = id_valid & ex_valid & ex_is_load & ex_we &
               ((id_use1 & (id_a1 == ex_rd)) | (id_use2 & (id_a2 == ex_rd)));
      id_stall = ex_stall | (hazard & ~flush);
      // Register file only writes at the edge, so forward the in-flight write.
      op1 = (wb_we && (wb_addr == id_a1)) ? wb_data : rd1;
      op2 = (wb_we && (wb_addr == id_a2)) ? wb_data : rd2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid   <= 1'b0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_imm     <= '0;
         ex_rd      <= '0;
         ex_we      <= 1'b0;
         ex_is_load <= 1'b0;
         ex_ctrl    <= '0;
         bubble_cnt <= '0;
      end else if (flush || (!ex_stall && hazard)) begin
         ex_valid   <= 1'b0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_imm     <= '0;
         ex_rd      <= '0;
         ex_we      <= 1'b0;
         ex_is_load <= 1'b0;
         ex_ctrl    <= '0;
         if (!flush && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end
      end else if (!ex_stall) begin
         ex_valid   <= id_valid;
         ex_op1     <= op1;
         ex_op2     <= op2;
         ex_imm     <= id_imm;
         ex_rd      <= id_rd;
         ex_we      <= id_we & id_valid;
         ex_is_load <= id_is_load & id_valid;
         ex_ctrl    <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural model
// built around a shadow register file and the latest-value operand rule.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_use1, id_use2, id_we, id_is_load;
   logic [4:0]  id_a1, id_a2, id_rd, wb_addr;
   logic [31:0] id_imm, rd1, rd2, wb_data;
   logic [7:0]  id_ctrl;
   logic        wb_we, ex_stall, flush;
   logic        id_stall, ex_valid, ex_we, ex_is_load;
   logic [31:0] ex_op1, ex_op2, ex_imm;
   logic [4:0]  ex_rd;
   logic [7:0]  ex_ctrl;
   logic [15:0] bubble_cnt;

   logic [31:0] regs [32];
   assign rd1 = regs[id_a1];
   assign rd2 = regs[id_a2];

   // Model of the instruction sitting in EX.
   logic        m_valid, m_we, m_load;
   logic [31:0] m_op1, m_op2, m_imm;
   logic [4:0]  m_rd;
   logic [7:0]  m_ctrl;
   int          m_cnt;

   int passed = 0;
   int total = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_a1(id_a1), .id_a2(id_a2),
      .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_we(id_we),
      .id_is_load(id_is_load), .id_imm(id_imm), .id_ctrl(id_ctrl), .rd1(rd1), .rd2(rd2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_stall(ex_stall),
      .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_op1(ex_op1),
      .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_we(ex_we),
      .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Decode reads a register that the load now in EX will produce.
   function automatic bit load_use();
      return id_valid && m_valid && m_load && m_we &&
             ((id_use1 && id_a1 == m_rd) || (id_use2 && id_a2 == m_rd));
   endfunction

   // Latest value of a register, including a write landing this cycle.
   function automatic logic [31:0] newest(input logic [4:0] a);
      return (wb_we && wb_addr == a) ? wb_data : regs[a];
   endfunction

   task automatic model_empty();
      {m_valid, m_we, m_load, m_op1, m_op2, m_imm, m_rd, m_ctrl} = '0;
   endtask

   task automatic model_edge();
      if (!rst) begin
         model_empty();
         m_cnt = 0;
      end else if (flush) begin
         model_empty();
      end else if (ex_stall) begin
         // instruction in EX stays put
      end else if (load_use()) begin
         model_empty();
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
         m_valid = id_valid;
         m_op1 = newest(id_a1);
         m_op2 = newest(id_a2);
         m_imm = id_imm;
         m_rd = id_rd;
         m_we = id_we && id_valid;
         m_load = id_is_load && id_valid;
         m_ctrl = id_ctrl;
      end
      if (wb_we) regs[wb_addr] = wb_data;
   endtask

   task automatic check_ex();
      check("ex_valid", ex_valid, m_valid);
      check("ex_op1", ex_op1, m_op1);
      check("ex_op2", ex_op2, m_op2);
      check("ex_imm", ex_imm, m_imm);
      check("ex_rd", ex_rd, m_rd);
      check("ex_we", ex_we, m_we);
      check("ex_is_load", ex_is_load, m_load);
      check("ex_ctrl", ex_ctrl, m_ctrl);
      check("bubble_cnt", bubble_cnt, m_cnt);
   endtask

   // Inputs are set at the falling edge before calling step.
   task automatic step();
      #1;
      check("id_stall", id_stall, ex_stall || (load_use() && !flush));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_ex();
   endtask

   task automatic idle_inputs();
      {id_valid, id_use1, id_use2, id_we, id_is_load, wb_we, ex_stall, flush} = '0;
      {id_a1, id_a2, id_rd, wb_addr} = '0;
      {id_imm, wb_data, id_ctrl} = '0;
   endtask

   task automatic decode(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                         input logic we, input logic ld);
      id_valid = 1'b1; id_a1 = a1; id_a2 = a2; id_use1 = 1'b1; id_use2 = 1'b1;
      id_rd = rd; id_we = we; id_is_load = ld;
      id_imm = $urandom; id_ctrl = 8'($urandom);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      idle_inputs();
      model_empty();
      m_cnt = 0;
      rst = 1'b0;
      ex_stall = 1'b1;
      #12;
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_bubble_cnt", bubble_cnt, 16'h0);
      check("rst_stall_follows", id_stall, 1'b1);
      ex_stall = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Plain capture
      regs[3] = 32'h11; regs[4] = 32'h22;
      decode(5'd3, 5'd4, 5'd7, 1'b1, 1'b0);
      step();
      check("cap_op1", ex_op1, 32'h11);
      check("cap_op2", ex_op2, 32'h22);
      check("cap_rd", ex_rd, 5'd7);
      check("cap_we", {ex_valid, ex_we}, 2'b11);

      // Write-through bypass
      regs[9] = 32'h0;
      decode(5'd9, 5'd4, 5'd8, 1'b1, 1'b0);
      wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h20;
      step();
      check("bypass_op1", ex_op1, 32'h20);
      wb_we = 1'b0;

      // Load-use: one bubble, then the consumer is captured
      decode(5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
      step();
      decode(5'd6, 5'd5, 5'd10, 1'b1, 1'b0);
      id_use1 = 1'b0;
      #1 check("lu_stall", id_stall, 1'b1);
      step();
      check("lu_bubble", ex_valid, 1'b0);
      check("lu_cnt", bubble_cnt, 16'd1);
      check("lu_stall_clear", id_stall, 1'b0);
      step();
      check("lu_capture", {ex_valid, ex_rd}, {1'b1, 5'd10});

      // Hold under ex_stall, then flush wins over stall
      decode(5'd2, 5'd3, 5'd11, 1'b1, 1'b0);
      ex_stall = 1'b1;
      step();
      check("hold_rd", ex_rd, 5'd10);
      flush = 1'b1;
      step();
      check("flush_stall", {ex_valid, ex_we}, 2'b00);
      ex_stall = 1'b0; flush = 1'b0;

      // Randomized traffic on a small register window to provoke hits
      for (int n = 0; n < 400; n++) begin
         id_valid = ($urandom_range(0, 4) != 0);
         id_a1 = 5'($urandom_range(0, 7)); id_a2 = 5'($urandom_range(0, 7));
         id_use1 = 1'($urandom); id_use2 = 1'($urandom);
         id_rd = 5'($urandom_range(0, 7));
         id_we = ($urandom_range(0, 3) != 0); id_is_load = ($urandom_range(0, 2) == 0);
         id_imm = $urandom; id_ctrl = 8'($urandom);
         wb_we = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
         ex_stall = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 9) == 0);
         step();
      end
      idle_inputs();
      step();

      // Saturation: preload near the top, then force real load-use bubbles
      force dut.bubble_cnt = 16'hFFFD;
      #1 release dut.bubble_cnt;
      m_cnt = 16'hFFFD;
      for (int k = 0; k < 4; k++) begin
         decode(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
         id_use1 = 1'b0; id_use2 = 1'b0;
         step();
         decode(5'd5, 5'd0, 5'd12, 1'b1, 1'b0);
         id_use2 = 1'b0;
         step();
      end
      check("sat_cnt", bubble_cnt, 16'hFFFF);

      // Asynchronous reset mid-cycle with a load in EX and a stall pending
      decode(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
      step();
      decode(5'd5, 5'd0, 5'd13, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("arst_cnt", bubble_cnt, 16'h0);
      check("arst_valid", ex_valid, 1'b0);
      model_empty();
      m_cnt = 0;
      ex_stall = 1'b1;
      #1 check("arst_stall", id_stall, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      ex_stall = 1'b0;
      step();
      check("post_rst_capture", {ex_valid, ex_rd}, {1'b1, 5'd13});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
